// File: rtl/clock_timekeeper.sv
// Timekeeper for the digital clock: 1 Hz divider, BCD hh:mm:ss counter and button-driven setup FSM.
// Define SECONDS_VIEW_EN to add the SECONDS display mode to the btnMode cycle.
module clock_timekeeper #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned BLINK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnMode,
    input  logic       btnNext,
    input  logic       btnInc,
    output logic [1:0] mode,
    output logic [1:0] location,
    output logic [3:0] secondsLower,
    output logic [3:0] secondsUpper,
    output logic [3:0] minutesLower,
    output logic [3:0] minutesUpper,
    output logic [3:0] hoursLower,
    output logic [3:0] hoursUpper,
    output logic       tick1Hz,
    output logic       blink
);

    localparam int unsigned DivW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DivW-1:0] DivMax  = DivW'(CLK_HZ - 1);
    localparam int unsigned BlinkHigh   = (CLK_HZ / BLINK_DIV > 0) ? CLK_HZ / BLINK_DIV : 1;
    localparam int unsigned BlinkPeriod = 2 * BlinkHigh;

    typedef enum logic [1:0] {
        StSetup   = 2'b00,
        StTime24  = 2'b01,
        StSeconds = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      loc_q, loc_d;
    logic [DivW-1:0] divider_q, divider_d;
    logic            tick_q, tick_d;
    logic [3:0]      sl_q, sl_d, su_q, su_d;
    logic [3:0]      ml_q, ml_d, mu_q, mu_d;
    logic [3:0]      hl_q, hl_d, hu_q, hu_d;

    logic wrap;
    logic running;

    assign wrap    = (divider_q == DivMax);
    assign running = (state_q != StSetup);

    always_comb begin
        state_d   = state_q;
        loc_d     = loc_q;
        divider_d = wrap ? '0 : divider_q + DivW'(1);
        tick_d    = 1'b0;
        sl_d      = sl_q;
        su_d      = su_q;
        ml_d      = ml_q;
        mu_d      = mu_q;
        hl_d      = hl_q;
        hu_d      = hu_q;

        if (running && wrap) begin
            tick_d = 1'b1;
            if (sl_q == 4'd9) begin
                sl_d = 4'd0;
                if (su_q == 4'd5) begin
                    su_d = 4'd0;
                    if (ml_q == 4'd9) begin
                        ml_d = 4'd0;
                        if (mu_q == 4'd5) begin
                            mu_d = 4'd0;
                            if (hu_q == 4'd2 && hl_q == 4'd3) begin
                                hu_d = 4'd0;
                                hl_d = 4'd0;
                            end else if (hl_q == 4'd9) begin
                                hl_d = 4'd0;
                                hu_d = hu_q + 4'd1;
                            end else begin
                                hl_d = hl_q + 4'd1;
                            end
                        end else begin
                            mu_d = mu_q + 4'd1;
                        end
                    end else begin
                        ml_d = ml_q + 4'd1;
                    end
                end else begin
                    su_d = su_q + 4'd1;
                end
            end else begin
                sl_d = sl_q + 4'd1;
            end
        end

        // btnMode wins; edit buttons in the same cycle are dropped.
        if (btnMode) begin
            case (state_q)
                StSetup: begin
                    state_d   = StTime24;
                    sl_d      = 4'd0;
                    su_d      = 4'd0;
                    divider_d = '0;
                end
`ifdef SECONDS_VIEW_EN
                StTime24: state_d = StSeconds;
`endif
                default: begin
                    state_d = StSetup;
                    loc_d   = 2'd0;
                end
            endcase
        end else if (state_q == StSetup) begin
            if (btnInc) begin
                unique case (loc_q)
                    2'd0: begin
                        hu_d = (hu_q >= 4'd2) ? 4'd0 : hu_q + 4'd1;
                        // Moving to 2x must keep the hour at or below 23.
                        if (hu_q == 4'd1 && hl_q > 4'd3) hl_d = 4'd0;
                    end
                    2'd1: hl_d = ((hu_q == 4'd2 && hl_q >= 4'd3) || hl_q >= 4'd9) ?
                                 4'd0 : hl_q + 4'd1;
                    2'd2: mu_d = (mu_q >= 4'd5) ? 4'd0 : mu_q + 4'd1;
                    2'd3: ml_d = (ml_q >= 4'd9) ? 4'd0 : ml_q + 4'd1;
                endcase
            end
            if (btnNext) loc_d = loc_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StSetup;
            loc_q     <= 2'd0;
            divider_q <= '0;
            tick_q    <= 1'b0;
            sl_q      <= 4'd0;
            su_q      <= 4'd0;
            ml_q      <= 4'd0;
            mu_q      <= 4'd0;
            hl_q      <= 4'd0;
            hu_q      <= 4'd0;
        end else begin
            state_q   <= state_d;
            loc_q     <= loc_d;
            divider_q <= divider_d;
            tick_q    <= tick_d;
            sl_q      <= sl_d;
            su_q      <= su_d;
            ml_q      <= ml_d;
            mu_q      <= mu_d;
            hl_q      <= hl_d;
            hu_q      <= hu_d;
        end
    end

    assign mode         = state_q;
    assign location     = loc_q;
    assign secondsLower = sl_q;
    assign secondsUpper = su_q;
    assign minutesLower = ml_q;
    assign minutesUpper = mu_q;
    assign hoursLower   = hl_q;
    assign hoursUpper   = hu_q;
    assign tick1Hz      = tick_q;
    assign blink        = ((32'(divider_q) % BlinkPeriod) < BlinkHigh);

endmodule

// File: tb/tb_clock_timekeeper.sv
// Bench for clock_timekeeper at CLK_HZ=10: directed button vectors feed a state scoreboard and a
// tick scoreboard drained by a negedge monitor. Define SECONDS_VIEW_EN to cover the seconds view.
module tb_clock_timekeeper;

    localparam int unsigned ClkHz = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btnMode, btnNext, btnInc;
    logic [1:0] mode, location;
    logic [3:0] sl, su, ml, mu, hl, hu;
    logic       tick1Hz, blink;

    always #5 clk = ~clk;

    clock_timekeeper #(
        .CLK_HZ   (ClkHz),
        .BLINK_DIV(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btnMode     (btnMode),
        .btnNext     (btnNext),
        .btnInc      (btnInc),
        .mode        (mode),
        .location    (location),
        .secondsLower(sl),
        .secondsUpper(su),
        .minutesLower(ml),
        .minutesUpper(mu),
        .hoursLower  (hl),
        .hoursUpper  (hu),
        .tick1Hz     (tick1Hz),
        .blink       (blink)
    );

    typedef struct packed {
        logic [1:0]  mode;
        logic [1:0]  loc;
        logic [23:0] digits;
        logic        tick;
        logic        blink;
        logic        chk_blink;
    } snap_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [23:0] digits;
    } tick_t;

    snap_t       exp_q[$];
    string       name_q[$];
    tick_t       tick_q[$];
    snap_t       mon_e;
    string       mon_nm;
    tick_t       mon_t;
    int unsigned cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    int unsigned c0, c1, c2;
    logic [23:0] dut_digits;

    assign dut_digits = {hu, hl, mu, ml, su, sl};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            compared++;
            if (mode !== mon_e.mode || location !== mon_e.loc || dut_digits !== mon_e.digits ||
                tick1Hz !== mon_e.tick || (mon_e.chk_blink && blink !== mon_e.blink)) begin
                mismatched++;
                $display("FAIL %s: got mode=%b loc=%0d hhmmss=%h tick=%b blink=%b; required mode=%b loc=%0d hhmmss=%h tick=%b blink=%b",
                         mon_nm, mode, location, dut_digits, tick1Hz, blink,
                         mon_e.mode, mon_e.loc, mon_e.digits, mon_e.tick,
                         mon_e.chk_blink ? mon_e.blink : blink);
            end
        end
        if (tick1Hz === 1'b1) begin
            compared++;
            if (tick_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_tick: got tick at cycle %0d hhmmss=%h; required no tick",
                         cyc, dut_digits);
            end else begin
                mon_t = tick_q.pop_front();
                if (cyc != mon_t.cyc || dut_digits !== mon_t.digits) begin
                    mismatched++;
                    $display("FAIL tick: got cycle %0d hhmmss=%h; required cycle %0d hhmmss=%h",
                             cyc, dut_digits, mon_t.cyc, mon_t.digits);
                end
            end
        end
    end

    task automatic press(input logic m, input logic n, input logic i);
        @(negedge clk);
        btnMode = m;
        btnNext = n;
        btnInc  = i;
        @(posedge clk);
        #1;
        btnMode = 1'b0;
        btnNext = 1'b0;
        btnInc  = 1'b0;
    endtask

    task automatic press_n(input int count, input logic n, input logic i);
        for (int k = 0; k < count; k++) press(1'b0, n, i);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string nm, input logic [1:0] m, input logic [1:0] l,
                             input logic [23:0] d, input logic t);
        exp_q.push_back('{mode: m, loc: l, digits: d, tick: t, blink: 1'b0, chk_blink: 1'b0});
        name_q.push_back(nm);
    endtask

    task automatic expect_blink(input string nm, input logic [1:0] m, input logic [1:0] l,
                                input logic [23:0] d, input logic t, input logic b);
        exp_q.push_back('{mode: m, loc: l, digits: d, tick: t, blink: b, chk_blink: 1'b1});
        name_q.push_back(nm);
    endtask

    function automatic logic [23:0] time_digits(input int unsigned t);
        int unsigned h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Tick k after the mode-entry edge lands ClkHz*k cycles later, showing base+k seconds.
    task automatic push_ticks(input int unsigned cstart, input int unsigned base,
                              input int unsigned first, input int unsigned last);
        for (int unsigned k = first; k <= last; k++)
            tick_q.push_back('{cyc: 32'(cstart + ClkHz * k),
                               digits: time_digits((base + k) % 86400)});
    endtask

    initial begin
        rst_n   = 1'b0;
        btnMode = 1'b0;
        btnNext = 1'b0;
        btnInc  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_blink("reset", 2'b00, 2'd0, 24'h000000, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        press_n(4, 1'b1, 1'b0);
        expect_st("next_wrap", 2'b00, 2'd0, 24'h000000, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        expect_st("next_5", 2'b00, 2'd1, 24'h000000, 1'b0);

        press_n(7, 1'b0, 1'b1);
        expect_st("hl_7", 2'b00, 2'd1, 24'h070000, 1'b0);
        press_n(3, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        expect_st("hu_1", 2'b00, 2'd0, 24'h170000, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        expect_st("hu_2_clamp", 2'b00, 2'd0, 24'h200000, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        expect_st("hl_1", 2'b00, 2'd1, 24'h210000, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        expect_st("hl_2", 2'b00, 2'd1, 24'h220000, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        expect_st("hl_3", 2'b00, 2'd1, 24'h230000, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        expect_st("hl_wrap_at_2x", 2'b00, 2'd1, 24'h200000, 1'b0);

        press_n(3, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        press_n(5, 1'b0, 1'b1);
        expect_st("mu_5", 2'b00, 2'd2, 24'h235000, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        expect_st("inc_with_next", 2'b00, 2'd3, 24'h230000, 1'b0);

        press_n(3, 1'b1, 1'b0);
        press_n(5, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        press_n(9, 1'b0, 1'b1);
        expect_st("set_2359", 2'b00, 2'd3, 24'h235900, 1'b0);

        press(1'b1, 1'b1, 1'b1);
        c0 = cyc;
        expect_st("mode_priority", 2'b01, 2'd3, 24'h235900, 1'b0);
        push_ticks(c0, 23 * 3600 + 59 * 60, 1, 61);
        wait_cycles(4);
        expect_blink("blink_high", 2'b01, 2'd3, 24'h235900, 1'b0, 1'b1);
        wait_cycles(1);
        expect_blink("blink_low", 2'b01, 2'd3, 24'h235900, 1'b0, 1'b0);
        wait_cycles(585);
        expect_st("at_235959", 2'b01, 2'd3, 24'h235959, 1'b1);
        wait_cycles(10);
        expect_st("rollover", 2'b01, 2'd3, 24'h000000, 1'b1);
        wait_cycles(10);
        expect_st("after_rollover", 2'b01, 2'd3, 24'h000001, 1'b1);

        press(1'b1, 1'b0, 1'b0);
        expect_st("to_setup", 2'b00, 2'd0, 24'h000001, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        press_n(2, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        press_n(3, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        press_n(4, 1'b0, 1'b1);
        expect_st("set_1234", 2'b00, 2'd3, 24'h123401, 1'b0);

        press(1'b1, 1'b0, 1'b0);
        c1 = cyc;
        expect_st("run_1234", 2'b01, 2'd3, 24'h123400, 1'b0);
        push_ticks(c1, 12 * 3600 + 34 * 60, 1, 56);
        wait_cycles(560);
        expect_st("at_123456", 2'b01, 2'd3, 24'h123456, 1'b1);

        @(negedge clk);
        rst_n   = 1'b0;
        btnMode = 1'b1;
        btnNext = 1'b1;
        btnInc  = 1'b1;
        @(posedge clk);
        #1;
        expect_blink("midrun_reset", 2'b00, 2'd0, 24'h000000, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        expect_blink("reset_ignores_buttons", 2'b00, 2'd0, 24'h000000, 1'b0, 1'b1);
        @(negedge clk);
        rst_n   = 1'b1;
        btnMode = 1'b0;
        btnNext = 1'b0;
        btnInc  = 1'b0;

        press(1'b1, 1'b0, 1'b0);
        c2 = cyc;
        expect_st("run_again", 2'b01, 2'd0, 24'h000000, 1'b0);
        push_ticks(c2, 0, 1, 1);
`ifdef SECONDS_VIEW_EN
        push_ticks(c2, 0, 2, 3);
`endif
        wait_cycles(13);
        press(1'b1, 1'b0, 1'b0);
`ifdef SECONDS_VIEW_EN
        expect_st("to_seconds", 2'b10, 2'd0, 24'h000001, 1'b0);
        wait_cycles(20);
        press(1'b1, 1'b0, 1'b0);
        expect_st("seconds_to_setup", 2'b00, 2'd0, 24'h000003, 1'b0);
        wait_cycles(30);
        expect_st("frozen", 2'b00, 2'd0, 24'h000003, 1'b0);
`else
        expect_st("back_to_setup", 2'b00, 2'd0, 24'h000001, 1'b0);
        wait_cycles(30);
        expect_st("frozen", 2'b00, 2'd0, 24'h000001, 1'b0);
`endif

        @(negedge clk);
        @(negedge clk);
        compared++;
        if (tick_q.size() != 0 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drained: got %0d ticks and %0d states outstanding; required 0 and 0",
                     tick_q.size(), exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/clock_timekeeper.md
Name: clock_timekeeper

Overview:
- Time source and setup controller for the digital clock.
- Generates the 1 Hz tick and keeps hours, minutes and seconds as BCD digits.
- Runs the setup state machine driven by pre-debounced button pulses.
- Drives the mode, location and six digit inputs of the seven-segment display driver; the display driver only reads these signals, and this block is their sole writer.

Parameters:
- CLK_HZ, 50000000, input clock frequency; divider terminal count is CLK_HZ-1.
- BLINK_DIV, 2, blink toggles BLINK_DIV times per second (high for first CLK_HZ/BLINK_DIV counts of each half-period pair).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- btnMode  in  1  single-cycle pulse, already synchronised and debounced; mode change.
- btnNext  in  1  single-cycle pulse; advance setup location.
- btnInc  in  1  single-cycle pulse; increment digit at location.
- mode  out  2  00 SETUP, 01 TIME24, 10 SECONDS (feature only), 11 never driven.
- location  out  2  digit under edit: 0 hoursUpper, 1 hoursLower, 2 minutesUpper, 3 minutesLower.
- secondsLower, secondsUpper, minutesLower, minutesUpper, hoursLower, hoursUpper  out  4 each  BCD digits.
- tick1Hz  out  1  one-cycle pulse per counted second.
- blink  out  1  blink phase for the display driver.

Behaviour:
- Reset (rst_n low at clk edge): all digits 0, mode=SETUP, location=0, divider=0, tick1Hz=0, blink=1. Reset overrides all buttons.
- Divider:
  - Free-runs 0..CLK_HZ-1 in every mode and wraps to 0.
  - blink=1 while divider < CLK_HZ/2, else 0.
- tick1Hz:
  - Asserted for exactly the one cycle after the edge where divider==CLK_HZ-1.
  - Only in TIME24 (or SECONDS); held 0 in SETUP.
- Counting (TIME24):
  - Digits update on the same edge that sets tick1Hz; they are registered outputs with no additional latency.
  - Cascade: secondsLower 9->0 carries to secondsUpper; 5->0 carries to minutesLower; minutes behave likewise.
  - Hours: hoursLower 9->0 carries, except 23 -> 00.
  - 23:59:59 -> 00:00:00 in a single tick.
- State machine:
  - SETUP --btnMode--> TIME24: secondsLower and secondsUpper cleared, divider cleared to 0. The first tick follows exactly CLK_HZ cycles later.
  - TIME24 --btnMode--> SETUP: location=0, digits retained, counting frozen.
- Setup editing (SETUP only; buttons ignored otherwise):
  - btnNext: location = location+1 mod 4.
  - btnInc at location 0: hoursUpper 0->1->2->0. If it becomes 2 and hoursLower>3, hoursLower forced to 0 on the same edge.
  - btnInc at location 1: hoursLower wraps 9->0, or 3->0 when hoursUpper==2.
  - btnInc at location 2: minutesUpper wraps 5->0.
  - btnInc at location 3: minutesLower wraps 9->0.
- Simultaneous events:
  - btnMode has priority; btnNext and btnInc in the same cycle are dropped.
  - btnInc with btnNext: the increment applies to the old location, then location advances.
- Invariant: digits never leave legal BCD ranges (hours 00-23, minutes/seconds 00-59).

Optional Feature:
- Macro: SECONDS_VIEW_EN.
- Defined:
  - btnMode cycles SETUP -> TIME24 -> SECONDS -> SETUP.
  - SECONDS drives mode=10 and keeps counting and ticking identically to TIME24.
  - SECONDS -> SETUP resets location=0 and freezes counting.
  - TIME24 -> SECONDS causes no divider or digit disturbance.
- Undefined: btnMode toggles SETUP <-> TIME24 only; mode never equals 10.

Test Plan:
- Reset/setup entry (CLK_HZ=10): hold rst_n low 3 cycles, release -> all digits 0, mode=00, location=0, tick1Hz=0. Pulse btnNext 5 times -> location=1.
- Hours clamp: at location 0 set hoursLower=7 via location 1 (7 btnInc), then 2 btnInc at location 0 -> hoursUpper=2, hoursLower=0. A further btnInc at location 1 four times -> 1,2,3,0.
- Rollover: set 23:59 in SETUP, btnMode -> mode=01, seconds 00. After 59 ticks -> 23:59:59. Next tick -> 00:00:00; tick1Hz pulses exactly every 10 cycles.
- Priority: in SETUP pulse btnMode+btnInc+btnNext in the same cycle -> mode=01, digits and location unchanged. Separately, btnInc+btnNext at location 2 with minutesUpper=5 -> minutesUpper=0, location=3.
- Mid-run reset: drive rst_n low while counting at 12:34:56 -> next edge all zero, mode=00. Buttons pulsed during reset have no effect.
- SECONDS_VIEW_EN: three btnMode pulses -> mode 01, 10, 00. Ticks continue in 10; counting frozen after returning to 00. Without the macro, a second btnMode pulse returns mode to 00.
